satatrn_txcrc: RTL and testbench



---
 rtl/satatrn_pkg.sv | 28 ++
 rtl/satatrn_crcstep.sv | 14 +
 rtl/satatrn_txcrc.sv | 86 ++++++++
 tb/tb_satatrn_txcrc.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/satatrn_pkg.sv
// Shared SATA transport constants and the one-dword CRC-32 advance used by tx and rx paths.
package satatrn_pkg;

  localparam logic [31:0] SATA_CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] SATA_CRC_INIT      = 32'h52325032;
  localparam int unsigned SATA_MAXFIS_DWORDS = 2049;
  localparam int unsigned SATA_LEN_W         = 12;

  typedef enum logic {
    StData = 1'b0,
    StCrc  = 1'b1
  } crc_state_e;

  // Non-reflected CRC, data bit 31 enters first.
  function automatic logic [31:0] sata_crc_step(input logic [31:0] crc, input logic [31:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ data[i]) begin
        c = {c[30:0], 1'b0} ^ SATA_CRC_POLY;
      end else begin
        c = {c[30:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/satatrn_crcstep.sv
// Combinational advance of the SATA CRC-32 by one 32-bit dword.
module satatrn_crcstep
  import satatrn_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [31:0] i_data,
  output logic [31:0] o_crc
);

  always_comb begin
    o_crc = sata_crc_step(i_crc, i_data);
  end

endmodule

// File: rtl/satatrn_txcrc.sv
// Transmit CRC appender: forwards FIS dwords through one output register and appends the CRC
// dword as the new final dword, flagging frames longer than MAXLEN input dwords.
module satatrn_txcrc
  import satatrn_pkg::*;
#(
  parameter bit          OPT_LOWPOWER = 1'b0,
  parameter int unsigned MAXLEN       = SATA_MAXFIS_DWORDS
) (
  input  logic        i_phy_clk,
  input  logic        i_phy_reset_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_data,
  input  logic        i_last,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_data,
  output logic        o_last,
  output logic        o_err_toolong
);

  localparam logic [SATA_LEN_W-1:0] MaxLen = SATA_LEN_W'(MAXLEN);

  crc_state_e            crc_pending;
  logic [31:0]           crc_q;
  logic [31:0]           crc_next;
  logic [SATA_LEN_W-1:0] len_q;
  logic                  advance;
  logic                  accept;

  satatrn_crcstep u_crcstep (
    .i_crc  (crc_q),
    .i_data (i_data),
    .o_crc  (crc_next)
  );

  assign advance = !o_valid || i_ready;
  assign o_ready = advance && (crc_pending == StData);
  assign accept  = i_valid && o_ready;

  always_ff @(posedge i_phy_clk) begin
    if (!i_phy_reset_n) begin
      o_valid       <= 1'b0;
      o_last        <= 1'b0;
      o_data        <= '0;
      o_err_toolong <= 1'b0;
      crc_pending   <= StData;
      crc_q         <= SATA_CRC_INIT;
      len_q         <= '0;
    end else begin
      // Fires once: the counter passes MAXLEN only once before it clears or saturates.
      o_err_toolong <= accept && (len_q == MaxLen);

      if (advance) begin
        if (crc_pending == StCrc) begin
          o_valid     <= 1'b1;
          o_data      <= crc_q;
          o_last      <= 1'b1;
          crc_pending <= StData;
          crc_q       <= SATA_CRC_INIT;
        end else if (i_valid) begin
          o_valid     <= 1'b1;
          o_data      <= i_data;
          o_last      <= 1'b0;
          crc_q       <= crc_next;
          crc_pending <= i_last ? StCrc : StData;
        end else begin
          o_valid <= 1'b0;
          o_last  <= 1'b0;
          if (OPT_LOWPOWER) begin
            o_data <= '0;
          end
        end
      end

      if (accept) begin
        if (i_last) begin
          len_q <= '0;
        end else if (len_q != '1) begin
          len_q <= len_q + SATA_LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_satatrn_txcrc.sv
// Directed bench for satatrn_txcrc with a scoreboard queue of expected {last, data} dwords.
module tb_satatrn_txcrc;

  localparam logic [31:0] CrcInit = 32'h52325032;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b0;
  logic        i_last = 1'b0;
  logic [31:0] i_data = '0;
  logic        o_ready;
  logic        o_valid;
  logic        o_last;
  logic        o_err;
  logic [31:0] o_data;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [32:0] exp_q[$];
  int          fire_cyc[$];
  int          fire_cnt = 0;
  int          cyc = 0;
  int          err_cnt = 0;
  int          err_fire_at = -1;
  int          rdy_mode = 0;
  logic [31:0] model = CrcInit;

  satatrn_txcrc #(
    .OPT_LOWPOWER (1'b1),
    .MAXLEN       (2049)
  ) dut (
    .i_phy_clk     (clk),
    .i_phy_reset_n (rst_n),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_data        (i_data),
    .i_last        (i_last),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_data        (o_data),
    .o_last        (o_last),
    .o_err_toolong (o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Register-wide formulation: fold the dword in, then shift 32 times.
  function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c ^ d;
    repeat (32) r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream ready pattern: 0 = always, 1 = toggle, 2 = random, else stalled.
  initial forever begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0:       i_ready = 1'b1;
      1:       i_ready = ~i_ready;
      2:       i_ready = 1'($urandom_range(0, 1));
      default: i_ready = 1'b0;
    endcase
  end

  // Output monitor: stability, low-power zeroing, error pulse, scoreboard pops.
  initial begin
    logic        prev_hold;
    logic        prev_rst;
    logic [32:0] prev_out;
    logic [32:0] e;
    prev_hold = 1'b0;
    prev_rst  = 1'b0;
    prev_out  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && prev_rst && prev_hold) begin
        chk("hold_valid", 64'(o_valid), 64'(1));
        chk("hold_dword", 64'({o_last, o_data}), 64'(prev_out));
      end
      if (rst_n && !o_valid) chk("lowpower_zero", 64'(o_data), 64'(0));
      if (o_err) begin
        err_cnt++;
        err_fire_at = fire_cnt;
      end
      if (rst_n && o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_output", 64'(exp_q.size()), 64'(1));
        end else begin
          e = exp_q.pop_front();
          chk("out_dword", 64'({o_last, o_data}), 64'(e));
        end
        fire_cnt++;
        fire_cyc.push_back(cyc);
      end
      prev_hold = o_valid && !i_ready;
      prev_out  = {o_last, o_data};
      prev_rst  = rst_n;
    end
  end

  task automatic send(input logic [31:0] d, input logic last);
    int w;
    w       = 0;
    i_valid = 1'b1;
    i_data  = d;
    i_last  = last;
    @(negedge clk);
    while (!o_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!o_ready) chk("accept_timeout", 64'(o_ready), 64'(1));
    exp_q.push_back({1'b0, d});
    model = crc_model(model, d);
    if (last) begin
      exp_q.push_back({1'b1, model});
      model = CrcInit;
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 5000) begin
      @(posedge clk);
      w++;
    end
    chk("drain", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int nb;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(o_valid), 64'(0));
    chk("rst_last", 64'(o_last), 64'(0));
    chk("rst_err", 64'(o_err), 64'(0));
    chk("rst_data", 64'(o_data), 64'(0));
    chk("rst_ready", 64'(o_ready), 64'(1));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-dword frame, one input bubble.
    base = fire_cnt;
    send(32'h00000046, 1'b1);
    nb = 0;
    repeat (4) begin
      @(negedge clk);
      if (!o_ready) nb++;
    end
    drain();
    chk("t1_bubble", 64'(nb), 64'(1));
    chk("t1_outputs", 64'(fire_cnt - base), 64'(2));

    // Five-dword frame with toggling ready.
    rdy_mode = 1;
    base = fire_cnt;
    send(32'h00000046, 1'b0);
    send(32'h11111111, 1'b0);
    send(32'h22222222, 1'b0);
    send(32'h33333333, 1'b0);
    send(32'h44444444, 1'b1);
    drain();
    chk("t2_outputs", 64'(fire_cnt - base), 64'(6));

    // Back-to-back 3-dword frames, contiguous output.
    rdy_mode = 0;
    @(posedge clk);
    #1;
    fire_cyc.delete();
    base = fire_cnt;
    for (int f = 0; f < 2; f++) begin
      send(32'h00000046, 1'b0);
      send(32'hA5A50000 + 32'(f), 1'b0);
      send(32'h0F0F0F0F ^ 32'(f), 1'b1);
    end
    drain();
    chk("t3_outputs", 64'(fire_cnt - base), 64'(8));
    chk("t3_contiguous", 64'(fire_cyc[7] - fire_cyc[0]), 64'(7));

    // Over-long frame: 2050 input dwords.
    err_cnt = 0;
    base = fire_cnt;
    for (int i = 0; i < 2050; i++) begin
      send((i == 0) ? 32'h00000046 : 32'(i), (i == 2049));
    end
    drain();
    chk("t4_err_pulses", 64'(err_cnt), 64'(1));
    chk("t4_err_position", 64'(err_fire_at - base), 64'(2049));
    chk("t4_outputs", 64'(fire_cnt - base), 64'(2051));

    // Reset with three dwords of a frame in flight.
    send(32'h00000046, 1'b0);
    send(32'h12345678, 1'b0);
    send(32'h9ABCDEF0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t5a_valid", 64'(o_valid), 64'(0));
    chk("t5a_ready", 64'(o_ready), 64'(1));
    exp_q.delete();
    model = CrcInit;
    rst_n = 1'b1;
    base = fire_cnt;
    send(32'h00000046, 1'b0);
    send(32'hCAFEF00D, 1'b1);
    drain();
    chk("t5a_outputs", 64'(fire_cnt - base), 64'(3));

    // Reset while the CRC dword is pending.
    rdy_mode = 3;
    @(posedge clk);
    #1;
    send(32'h00000055, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t5b_valid", 64'(o_valid), 64'(0));
    chk("t5b_last", 64'(o_last), 64'(0));
    exp_q.delete();
    model = CrcInit;
    rst_n = 1'b1;
    rdy_mode = 2;
    base = fire_cnt;
    send(32'h00000046, 1'b0);
    send(32'h0BADBEEF, 1'b1);
    drain();
    chk("t5b_outputs", 64'(fire_cnt - base), 64'(3));

    // Idle with low-power zeroing.
    rdy_mode = 0;
    repeat (5) begin
      @(negedge clk);
      chk("t6_idle_valid", 64'(o_valid), 64'(0));
      chk("t6_idle_data", 64'(o_data), 64'(0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
